// File: rtl/argo_chan_reader.sv
// argo_chan_reader: Argo channel read stage with a latency-hiding prefetch buffer
// Ports: clk/rst (sync, active-high); fifo_empty/fifo_rd_en/fifo_rd_data face the channel FIFO;
//        out_valid/out_ready/out_data form the consumer stream; buf_count is buffer occupancy.
// Optional: define ARGO_CHAN_STATS_EN to add item_total/stall_total counters and a per-pop trace.
module argo_chan_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_AW     = 2,
    parameter int CHAN_ID    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [BUF_AW:0]       buf_count
`ifdef ARGO_CHAN_STATS_EN
    ,
    output logic [31:0]           item_total,
    output logic [31:0]           stall_total
`endif
);
    localparam int BUF_DEPTH = 1 << BUF_AW;

    if (RD_LATENCY < 1 || RD_LATENCY > 3 || BUF_DEPTH < RD_LATENCY + 1 || CHAN_ID < 0) begin : g_bad_cfg
        $error("argo_chan_reader: invalid RD_LATENCY/BUF_AW/CHAN_ID combination");
    end

    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [BUF_AW-1:0]     r_wr_ptr;
    logic [BUF_AW-1:0]     r_rd_ptr;
    logic [BUF_AW:0]       r_count;
    logic [RD_LATENCY-1:0] r_sr;
    logic [BUF_AW+1:0]     w_inflight;
    logic [BUF_AW+1:0]     w_sum;
    logic                  w_cap;
    logic                  w_pop;

    // Every set bit is a read whose data is not yet in the buffer, including the one landing this edge,
    // so buf_count + inflight is the worst-case occupancy the buffer must absorb.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            w_inflight = w_inflight + (BUF_AW+2)'(r_sr[i]);
    end

    assign w_sum      = {1'b0, r_count} + w_inflight;
    assign w_cap      = r_sr[RD_LATENCY-1];
    assign w_pop      = out_valid && out_ready;
    assign fifo_rd_en = !rst && !fifo_empty && (w_sum < (BUF_AW+2)'(BUF_DEPTH));
    assign out_valid  = (r_count != '0);
    assign out_data   = r_buf[r_rd_ptr];
    assign buf_count  = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                r_buf[i] <= '0;
        end else begin
            r_sr <= (r_sr << 1) | RD_LATENCY'(fifo_rd_en);
            if (w_cap) begin
                r_buf[r_wr_ptr] <= fifo_rd_data;
                r_wr_ptr        <= r_wr_ptr + BUF_AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + BUF_AW'(1);
            r_count <= r_count + (BUF_AW+1)'(w_cap) - (BUF_AW+1)'(w_pop);
        end
    end

`ifdef ARGO_CHAN_STATS_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle     <= '0;
            item_total  <= '0;
            stall_total <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_pop) begin
                item_total <= item_total + 32'd1;
                $display("argo_chan_reader cycle %0d chan %0d pop 0x%0h", r_cycle, CHAN_ID, out_data);
            end
            if (!out_valid && out_ready)
                stall_total <= stall_total + 32'd1;
        end
    end
`endif
endmodule
